// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - single-bullet projectile controller with launch, flight, retire and cooldown.
// Define BULLET_AUTOFIRE_EN to relaunch while fire is held instead of on rising edges only.
module bullet_ctrl #(
  parameter int          SPEED       = 8,
  parameter int          SCREEN_W    = 640,
  parameter int          BULLET_SIZE = 4,
  parameter int          SPAWN_DY    = 14,
  parameter int          COOLDOWN    = 8,
  parameter logic [24:0] SPRITE_BASE = 25'd243648
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        fire,
  input  logic        facing,
  input  logic [9:0]  Player_X,
  input  logic [9:0]  Player_Y,
  input  logic        hit,
  input  logic [9:0]  DrawX_write,
  input  logic [9:0]  DrawY_write,
  output logic [9:0]  Bullet_X,
  output logic [9:0]  Bullet_Y,
  output logic        active,
  output logic        isBullet,
  output logic [24:0] Bullet_address
);

  localparam int          CW      = $clog2(COOLDOWN) + 1;
  localparam logic [10:0] SPEED11 = 11'(SPEED);
  localparam logic [10:0] W11     = 11'(SCREEN_W);
  localparam logic [10:0] SIZE11  = 11'(BULLET_SIZE);
  localparam logic [9:0]  PARK    = 10'h3FF;

  typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

  state_t        state, state_n;
  logic          fire_q, dir, dir_n, launch;
  logic [9:0]    bx_n, by_n;
  logic [CW-1:0] cool_cnt, cnt_n;
  logic [10:0]   px11, bx11;

  assign px11 = {1'b0, Player_X};
  assign bx11 = {1'b0, Bullet_X};

`ifdef BULLET_AUTOFIRE_EN
  assign launch = fire;
`else
  assign launch = fire & ~fire_q;
`endif

  always_comb begin
    state_n = state;
    bx_n    = Bullet_X;
    by_n    = Bullet_Y;
    dir_n   = dir;
    cnt_n   = cool_cnt;
    case (state)
      IDLE: begin
        // 11-bit compares keep a player near the right edge from wrapping the spawn X.
        if (launch && ((!facing && (px11 + 11'd32 < W11)) || (facing && (px11 >= SIZE11)))) begin
          state_n = FLY;
          dir_n   = facing;
          by_n    = Player_Y + 10'(SPAWN_DY);
          bx_n    = facing ? Player_X - 10'(BULLET_SIZE) : Player_X + 10'd32;
        end
      end
      FLY: begin
        if (hit || (!dir && (bx11 + SPEED11 >= W11)) || (dir && (bx11 < SPEED11))) begin
          state_n = COOL;
          bx_n    = PARK;
          by_n    = PARK;
          cnt_n   = CW'(COOLDOWN - 1);
        end else begin
          bx_n = dir ? Bullet_X - 10'(SPEED) : Bullet_X + 10'(SPEED);
        end
      end
      COOL: begin
        if (cool_cnt == '0) state_n = IDLE;
        else                cnt_n   = cool_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Bullet_X <= PARK;
      Bullet_Y <= PARK;
      active   <= 1'b0;
      fire_q   <= 1'b0;
      dir      <= 1'b0;
      cool_cnt <= '0;
    end else begin
      state    <= state_n;
      Bullet_X <= bx_n;
      Bullet_Y <= by_n;
      active   <= (state_n == FLY);
      fire_q   <= fire;
      dir      <= dir_n;
      cool_cnt <= cnt_n;
    end
  end

  logic [10:0] dx11, dy11;
  logic [31:0] dx32, dy32;

  assign dx11 = {1'b0, DrawX_write};
  assign dy11 = {1'b0, DrawY_write};
  assign dx32 = 32'(DrawX_write) - 32'(Bullet_X);
  assign dy32 = 32'(DrawY_write) - 32'(Bullet_Y);

  assign isBullet = active
                  && (dx11 >= bx11) && (dx11 < bx11 + SIZE11)
                  && (dy11 >= {1'b0, Bullet_Y}) && (dy11 < {1'b0, Bullet_Y} + SIZE11);

  assign Bullet_address = isBullet
                        ? 25'(32'(SPRITE_BASE) + dx32 + dy32 * 32'(BULLET_SIZE))
                        : 25'd0;

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - directed self-checking bench for bullet_ctrl (default build, autofire off).
module tb_bullet_ctrl;

  logic        frame_clk, Reset_n, fire, facing, hit;
  logic [9:0]  Player_X, Player_Y, DrawX_write, DrawY_write;
  logic [9:0]  Bullet_X, Bullet_Y;
  logic        active, isBullet;
  logic [24:0] Bullet_address;

  int checks = 0;
  int failures = 0;

  bullet_ctrl dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .fire(fire), .facing(facing),
    .Player_X(Player_X), .Player_Y(Player_Y), .hit(hit),
    .DrawX_write(DrawX_write), .DrawY_write(DrawY_write),
    .Bullet_X(Bullet_X), .Bullet_Y(Bullet_Y), .active(active),
    .isBullet(isBullet), .Bullet_address(Bullet_address)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle_wait;
    fire = 1'b0;
    hit  = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; fire = 1'b0; facing = 1'b0; hit = 1'b0;
    Player_X = 10'd268; Player_Y = 10'd100; DrawX_write = '0; DrawY_write = '0;
    tick(); tick();
    checks++;
    if (Bullet_X !== 10'h3FF || Bullet_Y !== 10'h3FF || active !== 1'b0 || isBullet !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: X=%h Y=%h active=%b isBullet=%b required 3ff 3ff 0 0",
               Bullet_X, Bullet_Y, active, isBullet);
    end
    Reset_n = 1'b1;
    tick();
    fire = 1'b1;
    tick();
    checks++;
    if (Bullet_X !== 10'd300 || active !== 1'b1) begin
      failures++;
      $display("FAIL reset_prelaunch: X=%0d active=%b required 300 1", Bullet_X, active);
    end
    fire = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (Bullet_X !== 10'h3FF || Bullet_Y !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: X=%h Y=%h active=%b required 3ff 3ff 0", Bullet_X, Bullet_Y, active);
    end
    Reset_n = 1'b1;
    tick();
    checks++;
    if (Bullet_X !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: X=%h active=%b required 3ff 0", Bullet_X, active);
    end
  endtask

  task automatic test_right;
    Player_X = 10'd100; Player_Y = 10'd200; facing = 1'b0; fire = 1'b1;
    tick();
    checks++;
    if (Bullet_X !== 10'd132 || Bullet_Y !== 10'd214 || active !== 1'b1) begin
      failures++;
      $display("FAIL right_launch: X=%0d Y=%0d active=%b required 132 214 1", Bullet_X, Bullet_Y, active);
    end
    fire = 1'b0;
    tick();
    checks++;
    if (Bullet_X !== 10'd140 || Bullet_Y !== 10'd214) begin
      failures++;
      $display("FAIL right_move1: X=%0d Y=%0d required 140 214", Bullet_X, Bullet_Y);
    end
    tick();
    checks++;
    if (Bullet_X !== 10'd148) begin
      failures++;
      $display("FAIL right_move2: X=%0d required 148", Bullet_X);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    idle_wait();
  endtask

  task automatic test_left;
    Player_X = 10'd20; Player_Y = 10'd50; facing = 1'b1; fire = 1'b1;
    tick();
    checks++;
    if (Bullet_X !== 10'd16 || Bullet_Y !== 10'd64 || active !== 1'b1) begin
      failures++;
      $display("FAIL left_launch: X=%0d Y=%0d active=%b required 16 64 1", Bullet_X, Bullet_Y, active);
    end
    fire = 1'b0;
    facing = 1'b0;
    tick();
    tick();
    checks++;
    if (Bullet_X !== 10'd0 || active !== 1'b1) begin
      failures++;
      $display("FAIL left_at_zero: X=%0d active=%b required 0 1", Bullet_X, active);
    end
    tick();
    checks++;
    if (Bullet_X !== 10'h3FF || Bullet_Y !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL left_retire: X=%h Y=%h active=%b required 3ff 3ff 0", Bullet_X, Bullet_Y, active);
    end
    for (int i = 0; i < 8; i++) tick();
    fire = 1'b1;
    tick();
    checks++;
    if (active !== 1'b1 || Bullet_X !== 10'd52) begin
      failures++;
      $display("FAIL left_cooldown_exit: active=%b X=%0d required 1 52", active, Bullet_X);
    end
    fire = 1'b0;
    hit = 1'b1;
    tick();
    idle_wait();
  endtask

  task automatic test_hit;
    Player_X = 10'd168; Player_Y = 10'd10; facing = 1'b0; fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (Bullet_X !== 10'd200 || active !== 1'b1) begin
      failures++;
      $display("FAIL hit_launch: X=%0d active=%b required 200 1", Bullet_X, active);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    checks++;
    if (Bullet_X !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL hit_park: X=%h active=%b required 3ff 0", Bullet_X, active);
    end
    tick(); tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL hit_fire_in_cool: active=%b required 0", active);
    end
    for (int i = 0; i < 4; i++) tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL hit_fire_last_cool: active=%b required 0", active);
    end
    tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (active !== 1'b1 || Bullet_X !== 10'd200) begin
      failures++;
      $display("FAIL hit_relaunch: active=%b X=%0d required 1 200", active, Bullet_X);
    end
    hit = 1'b1;
    tick();
    idle_wait();
  endtask

  task automatic test_edges;
    Player_X = 10'd600; facing = 1'b0; fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (Bullet_X !== 10'd632 || active !== 1'b1) begin
      failures++;
      $display("FAIL edge_launch632: X=%0d active=%b required 632 1", Bullet_X, active);
    end
    tick();
    checks++;
    if (Bullet_X !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL edge_retire_nowrap: X=%h active=%b required 3ff 0", Bullet_X, active);
    end
    idle_wait();
    Player_X = 10'd610; fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (Bullet_X !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL edge_refuse_right: X=%h active=%b required 3ff 0", Bullet_X, active);
    end
    tick();
    Player_X = 10'd3; facing = 1'b1; fire = 1'b1;
    tick();
    fire = 1'b0;
    checks++;
    if (Bullet_X !== 10'h3FF || active !== 1'b0) begin
      failures++;
      $display("FAIL edge_refuse_left: X=%h active=%b required 3ff 0", Bullet_X, active);
    end
    tick();
    facing = 1'b0;
  endtask

  task automatic test_draw_and_hold;
    Player_X = 10'd100; Player_Y = 10'd200; facing = 1'b0; fire = 1'b1;
    tick();
    DrawX_write = 10'd133; DrawY_write = 10'd216; #1;
    checks++;
    if (isBullet !== 1'b1 || Bullet_address !== 25'd243657) begin
      failures++;
      $display("FAIL draw_inside: isBullet=%b addr=%0d required 1 243657", isBullet, Bullet_address);
    end
    DrawX_write = 10'd136; DrawY_write = 10'd214; #1;
    checks++;
    if (isBullet !== 1'b0 || Bullet_address !== 25'd0) begin
      failures++;
      $display("FAIL draw_right_edge: isBullet=%b addr=%0d required 0 0", isBullet, Bullet_address);
    end
    DrawX_write = 10'd132; DrawY_write = 10'd217; #1;
    checks++;
    if (isBullet !== 1'b1 || Bullet_address !== 25'd243660) begin
      failures++;
      $display("FAIL draw_last_row: isBullet=%b addr=%0d required 1 243660", isBullet, Bullet_address);
    end
    DrawX_write = 10'd135; DrawY_write = 10'd218; #1;
    checks++;
    if (isBullet !== 1'b0 || Bullet_address !== 25'd0) begin
      failures++;
      $display("FAIL draw_below: isBullet=%b addr=%0d required 0 0", isBullet, Bullet_address);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (active !== 1'b0 || Bullet_X !== 10'h3FF) begin
      failures++;
      $display("FAIL hold_no_refire: active=%b X=%h required 0 3ff", active, Bullet_X);
    end
    fire = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_right();
    test_left();
    test_hit();
    test_edges();
    test_draw_and_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
